// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: state encoding and width limit.
package counter_pkg;

  localparam int unsigned CNT_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_up_counter.sv
// Loadable modulo-N up-counter with start/stop control and one-shot or
// periodic mode. tc is a registered one-cycle terminal-count pulse.
module mod_up_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2 || WIDTH > CNT_W_MAX) begin : g_bad_width
    $error("mod_up_counter: WIDTH out of range 2..32");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;

  // Next-state and next-count; priority is load > stop > start > count step
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else if (start && state_q != ST_RUN) begin
      // Restarting a finished one-shot begins a fresh period from zero
      if (state_q == ST_DONE) count_d = '0;
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      // >= so a loaded value above max_val terminates instead of running to 2^WIDTH
      if (count_q >= max_val) begin
        tc_d = 1'b1;
        if (periodic) begin
          count_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // State register; busy/done decode the next state so they track it exactly
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mod_up_counter.sv
// Bench for mod_up_counter: directed scenarios plus random stimulus, checked
// by a scoreboard fed from a behavioural model of the counting rules.
module tb_mod_up_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] max_val = '0;
  logic         periodic = 1'b0;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;

  mod_up_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .periodic (periodic),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Behavioural model: running/finished flags and an integer count
  int   m_cnt = 0;
  bit   m_run = 0;
  bit   m_fin = 0;
  bit   m_tc  = 0;

  int   cur_mx  = 0;
  bit   cur_per = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0;
    m_run = 0;
    m_fin = 0;
    m_tc  = 0;
  endfunction

  function automatic void model_step(bit st, bit sp, bit ld, int lv, int mx, bit per);
    m_tc = 0;
    if (ld) begin
      m_cnt = lv;
      m_fin = 0;
    end else if (sp) begin
      m_run = 0;
      m_fin = 0;
    end else if (st && !m_run) begin
      if (m_fin) m_cnt = 0;
      m_fin = 0;
      m_run = 1;
    end else if (m_run) begin
      if (m_cnt >= mx) begin
        m_tc = 1;
        if (per) m_cnt = 0;
        else begin
          m_run = 0;
          m_fin = 1;
        end
      end else begin
        m_cnt = (m_cnt + 1) % MOD;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.count = W'(m_cnt);
    e.tc    = m_tc;
    e.busy  = m_run;
    e.done  = m_fin;
    return e;
  endfunction

  // Drive one cycle of inputs and queue the response expected after the edge
  task automatic step(input bit st, input bit sp, input bit ld, input int lv);
    @(negedge clk);
    rstn     = 1'b1;
    start    = st;
    stop     = sp;
    load     = ld;
    load_val = W'(lv);
    max_val  = W'(cur_mx);
    periodic = cur_per;
    model_step(st, sp, ld, lv, cur_mx, cur_per);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 3 * MOD && m_cnt != target; i++) step(0, 0, 0, 0);
  endtask

  // Assert reset mid-cycle and check it acts before any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_tc", int'(tc), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    model_reset();
    exp_q.push_back(model_out());
  endtask

  // Monitor: compares every post-edge output against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'(count), int'(e.count));
        check("tc", int'(tc), int'(e.tc));
        check("busy", int'(busy), int'(e.busy));
        check("done", int'(done), int'(e.done));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Periodic mod-5
    cur_mx = 4; cur_per = 1;
    step(1, 0, 0, 0);
    idle(8);

    // Reset while running at count 5
    cur_mx = 9;
    run_until(5);
    do_reset();
    step(0, 0, 0, 0);
    idle(2);

    // One-shot to 3, then restart
    cur_mx = 3; cur_per = 0;
    step(1, 0, 0, 0);
    idle(6);
    step(1, 0, 0, 0);
    idle(2);

    // Load beats stop; 9 > max_val terminates on the next step
    cur_mx = 15; cur_per = 1;
    run_until(2);
    step(0, 1, 1, 9);
    idle(1);
    cur_mx = 7;
    run_until(2);
    step(0, 1, 1, 9);
    idle(2);

    // Stop / resume
    cur_mx = 15;
    run_until(6);
    step(0, 1, 0, 0);
    idle(10);
    step(1, 0, 0, 0);
    idle(2);

    // Full-range wrap, then max_val = 0
    run_until(15);
    idle(2);
    cur_mx = 0;
    idle(5);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      bit st, sp, ld;
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 15) == 0) cur_mx = $urandom_range(0, MOD - 1);
      if ($urandom_range(0, 31) == 0) cur_per = ~cur_per;
      ld = ($urandom_range(0, 11) == 0);
      sp = ($urandom_range(0, 13) == 0);
      st = ($urandom_range(0, 4) == 0);
      step(st, sp, ld, $urandom_range(0, MOD - 1));
    end

    @(negedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
